// File: rtl/multicycle_cpu_if.sv
// Shared memory bus between the multi-cycle core (master) and memory (slave).
// A transfer completes in any cycle where mem_req and mem_ack are both high.
interface multicycle_cpu_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-instruction core: FETCH -> EXEC (-> MEM) over one shared
// req/ack memory bus, with an internal register file and ALU.
module multicycle_cpu #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 12,
   parameter int NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_cpu_if.master  bus,
   output logic [ADDR_W-1:0] pc_out,
   output logic              retire,
   output logic              halted
);

   localparam logic [1:0] S_FETCH  = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_MEM    = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_ST   = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_BEQZ = 4'hC;
   localparam logic [3:0] OP_BNEZ = 4'hD;
   localparam logic [3:0] OP_SLT  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] rf_q [1:NUM_REGS-1];

   logic [3:0]        func, src1, src2, dest;
   logic [DATA_W-1:0] rs1, rs2, aluResult, rdData;
   logic              rdWrite, retireNow;
   logic [ADDR_W-1:0] pcInc, brTarget, jmpTarget;

   assign {func, src1, src2, dest} = ir_q;

   // R0 and indices beyond the implemented registers have no storage and read as 0.
   always_comb begin
      rs1 = '0;
      rs2 = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (src1 == 4'(i)) rs1 = rf_q[i];
         if (src2 == 4'(i)) rs2 = rf_q[i];
      end
   end

   // Shifts use the full R[src2] value; SV shifts already give 0 once it reaches DATA_W.
   always_comb begin
      case (func)
         OP_ADD:  aluResult = rs1 + rs2;
         OP_SUB:  aluResult = rs1 - rs2;
         OP_AND:  aluResult = rs1 & rs2;
         OP_OR:   aluResult = rs1 | rs2;
         OP_XOR:  aluResult = rs1 ^ rs2;
         OP_SHL:  aluResult = rs1 << rs2;
         OP_SHR:  aluResult = rs1 >> rs2;
         OP_LDI:  aluResult = DATA_W'($signed(ir_q[11:4]));
         OP_SLT:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         default: aluResult = '0;
      endcase
   end

   assign pcInc     = pc_q + ADDR_W'(1);
   assign brTarget  = pcInc + ADDR_W'($signed(ir_q[7:0]));
   assign jmpTarget = ADDR_W'(ir_q[11:0]);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      rdWrite   = 1'b0;
      rdData    = aluResult;
      retireNow = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata[15:0];
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d   = S_FETCH;
            pc_d      = pcInc;
            retireNow = 1'b1;
            case (func)
               OP_LD, OP_ST: begin
                  state_d   = S_MEM;
                  pc_d      = pc_q;
                  retireNow = 1'b0;
               end
               OP_JMP:  pc_d = jmpTarget;
               OP_BEQZ: if (rs1 == '0) pc_d = brTarget;
               OP_BNEZ: if (rs1 != '0) pc_d = brTarget;
               OP_HALT: state_d = S_HALTED;
               OP_NOP:  ;
               default: rdWrite = 1'b1;
            endcase
         end
         S_MEM: begin
            if (bus.mem_ack) begin
               state_d   = S_FETCH;
               pc_d      = pcInc;
               retireNow = 1'b1;
               rdWrite   = (func == OP_LD);
               rdData    = bus.mem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         for (int i = 1; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         for (int i = 1; i < NUM_REGS; i++) begin
            if (rdWrite && dest == 4'(i)) rf_q[i] <= rdData;
         end
      end
   end

   // Outputs are gated by reset so an access in flight is dropped immediately.
   assign bus.mem_req   = !reset && (state_q == S_FETCH || state_q == S_MEM);
   assign bus.mem_we    = !reset && (state_q == S_MEM) && (func == OP_ST);
   assign bus.mem_addr  = (state_q == S_MEM) ? rs1[ADDR_W-1:0] : pc_q;
   assign bus.mem_wdata = rs2;

   assign pc_out = pc_q;
   assign retire = !reset && retireNow;
   assign halted = !reset && (state_q == S_HALTED);

endmodule
